led_result_display: RTL and testbench

//  Registered successor of the combinational LED driver. Latches a signed-magnitude result
//  (magnitude + sign) on a capture strobe and holds it on DW+1 LEDs. Blinks the latched pattern
//  on overflow and blanks after an optional hold timeout. Sits between the multiplier/datapath

---
 rtl/leds_pkg.sv | 19 +
 rtl/led_result_display_blink_tick.sv | 46 ++++
 rtl/led_result_display.sv | 114 +++++++++++
 tb/tb_led_result_display.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared types and constants for the registered LED result display.
package leds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_ALARM
   } led_state_e;

   // Widest LED word supported; each user truncates to its own DW+1 word.
   localparam int unsigned LED_W_MAX = 256;
   typedef logic [LED_W_MAX-1:0] led_word_max_t;
   localparam led_word_max_t LED_BLANK = '0;

   function automatic int unsigned width_for(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_result_display_blink_tick.sv
// Blink phase generator: BLINK_DIV-cycle half-period counter, restartable to phase ON.
module led_blink_tick
   import leds_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   input  logic i_en,
   output logic o_on_d
);

   localparam int unsigned BW = width_for(BLINK_DIV);
   localparam logic [BW-1:0] CNT_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] cnt_q, cnt_d;
   logic          off_q, off_d;

   // Next phase is exported so the parent's output register sees it on the same edge.
   always_comb begin
      cnt_d = cnt_q;
      off_d = off_q;
      if (i_restart || !i_en) begin
         cnt_d = '0;
         off_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         off_d = ~off_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      o_on_d = ~off_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         off_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         off_q <= off_d;
      end
   end

endmodule

// File: rtl/led_result_display.sv
// Latches a signed-magnitude result on i_valid and drives it onto DW+1 LEDs,
// blinking on overflow and blanking after an optional hold timeout.
module led_result_display
   import leds_pkg::*;
#(
   parameter int unsigned DW         = 16,
   parameter int unsigned BLINK_DIV  = 25_000_000,
   parameter int unsigned HOLD_CYC   = 0,
   parameter bit          LED_ACT_LO = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   input  logic [DW-1:0] i_product,
   input  logic          i_sign,
   input  logic          i_ovf,
   input  logic          i_clear,
   output logic [DW:0]   o_led,
   output logic          o_ready,
   output logic          o_alarm
);

   typedef logic [DW:0] led_word_t;

   localparam int unsigned     HW        = width_for(HOLD_CYC);
   localparam logic [HW-1:0]   HOLD_LAST = (HOLD_CYC > 0) ? HW'(HOLD_CYC - 1) : '0;
   localparam led_word_t       BLANK     = led_word_t'(LED_BLANK);
   localparam led_word_t       POL_MASK  = {(DW+1){LED_ACT_LO}};

   led_state_e    state_q, state_d;
   led_word_t     latch_q, latch_d;
   logic [HW-1:0] hold_q,  hold_d;
   led_word_t     led_q,   led_d;
   logic          ready_q, ready_d;
   logic          alarm_q, alarm_d;

   logic          blink_restart;
   logic          blink_en;
   logic          blink_on_d;
   led_word_t     disp;

   // Priority: clear, then capture, then hold timeout.
   always_comb begin
      state_d       = state_q;
      latch_d       = latch_q;
      hold_d        = hold_q;
      blink_restart = 1'b0;
      if (i_clear) begin
         state_d = ST_IDLE;
         latch_d = BLANK;
         hold_d  = '0;
      end else if (i_valid) begin
         state_d       = i_ovf ? ST_ALARM : ST_SHOW;
         latch_d       = {i_sign, i_product};
         hold_d        = '0;
         blink_restart = 1'b1;
      end else if ((state_q != ST_IDLE) && (HOLD_CYC != 0)) begin
         if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   assign blink_en = (state_d == ST_ALARM);

   led_blink_tick #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_restart (blink_restart),
      .i_en      (blink_en),
      .o_on_d    (blink_on_d)
   );

   // Outputs are computed from next-state values so the display updates on the capture edge.
   always_comb begin
      disp = BLANK;
      unique case (state_d)
         ST_SHOW:  disp = latch_d;
         ST_ALARM: disp = blink_on_d ? latch_d : BLANK;
         default:  disp = BLANK;
      endcase
      led_d   = disp ^ POL_MASK;
      ready_d = (state_d != ST_IDLE);
      alarm_d = (state_d == ST_ALARM);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         latch_q <= BLANK;
         hold_q  <= '0;
         led_q   <= POL_MASK;
         ready_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         hold_q  <= hold_d;
         led_q   <= led_d;
         ready_q <= ready_d;
         alarm_q <= alarm_d;
      end
   end

   assign o_led   = led_q;
   assign o_ready = ready_q;
   assign o_alarm = alarm_q;

endmodule

// File: tb/tb_led_result_display.sv
// Bench: two instances (hold 10 / active-high, hold forever / active-low) against a capture-age model.
module tb_led_result_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] product = '0;
   logic        sign = 1'b0;
   logic        ovf = 1'b0;
   logic        clear = 1'b0;

   logic [16:0] led_a, led_b;
   logic        ready_a, ready_b, alarm_a, alarm_b;

   int n_vec = 0;
   int n_err = 0;

   // Model: a result is lit from its capture edge for HOLD cycles; overflow blinks by age/4.
   int          cyc = 0;
   bit          m_active = 1'b0;
   int          m_cap = 0;
   logic [16:0] m_val = '0;
   bit          m_ovf = 1'b0;

   led_result_display #(
      .DW(16), .BLINK_DIV(4), .HOLD_CYC(10), .LED_ACT_LO(1'b0)
   ) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_product(product),
      .i_sign(sign), .i_ovf(ovf), .i_clear(clear),
      .o_led(led_a), .o_ready(ready_a), .o_alarm(alarm_a)
   );

   led_result_display #(
      .DW(16), .BLINK_DIV(4), .HOLD_CYC(0), .LED_ACT_LO(1'b1)
   ) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_product(product),
      .i_sign(sign), .i_ovf(ovf), .i_clear(clear),
      .o_led(led_b), .o_ready(ready_b), .o_alarm(alarm_b)
   );

   always #5 clk = ~clk;

   function automatic bit m_lit(input int hold);
      int age;
      age = cyc - m_cap;
      return m_active && !((hold > 0) && (age >= hold));
   endfunction

   function automatic logic [16:0] exp_led(input int hold, input bit lo);
      logic [16:0] w;
      int age;
      w = '0;
      age = cyc - m_cap;
      if (m_lit(hold) && (!m_ovf || ((age / 4) % 2) == 0)) w = m_val;
      return lo ? ~w : w;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!rst_n || clear) begin
         m_active = 1'b0;
      end else if (valid) begin
         m_active = 1'b1;
         m_cap    = cyc;
         m_val    = {sign, product};
         m_ovf    = ovf;
      end
      #1;
   endtask

   task automatic drive_idle();
      valid = 1'b0;
      clear = 1'b0;
      ovf   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_active = 1'b0;
      tick();
      tick();
      n_vec++; if (led_a !== 17'h00000) begin n_err++; $display("FAIL reset_led_a: got %h want %h", led_a, 17'h00000); end
      n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
      n_vec++; if (alarm_a !== 1'b0) begin n_err++; $display("FAIL reset_alarm_a: got %b want 0", alarm_a); end
      n_vec++; if (led_b !== 17'h1FFFF) begin n_err++; $display("FAIL reset_led_b: got %h want %h", led_b, 17'h1FFFF); end
      rst_n = 1'b1;
      tick();
      n_vec++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL reset_idle_ready_b: got %b want 0", ready_b); end
   endtask

   task automatic test_capture();
      valid = 1'b1; product = 16'h00A5; sign = 1'b1; ovf = 1'b0;
      tick();
      drive_idle();
      n_vec++; if (led_a !== 17'h100A5) begin n_err++; $display("FAIL capture_led_a: got %h want %h", led_a, 17'h100A5); end
      n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL capture_ready_a: got %b want 1", ready_a); end
      n_vec++; if (alarm_a !== 1'b0) begin n_err++; $display("FAIL capture_alarm_a: got %b want 0", alarm_a); end
      n_vec++; if (led_b !== 17'h0FF5A) begin n_err++; $display("FAIL capture_led_b: got %h want %h", led_b, 17'h0FF5A); end
   endtask

   task automatic test_hold_timeout();
      logic [16:0] want;
      valid = 1'b1; product = 16'h1234; sign = 1'b0; ovf = 1'b0;
      tick();
      drive_idle();
      for (int i = 0; i < 12; i++) begin
         want = (i < 10) ? 17'h01234 : 17'h00000;
         n_vec++; if (led_a !== want) begin n_err++; $display("FAIL hold_led_a[%0d]: got %h want %h", i, led_a, want); end
         n_vec++; if (ready_a !== (i < 10)) begin n_err++; $display("FAIL hold_ready_a[%0d]: got %b want %b", i, ready_a, (i < 10)); end
         n_vec++; if (led_b !== 17'h1EDCB) begin n_err++; $display("FAIL hold_led_b[%0d]: got %h want %h", i, led_b, 17'h1EDCB); end
         tick();
      end
   endtask

   task automatic test_valid_at_timeout();
      valid = 1'b1; product = 16'h0F0F; sign = 1'b0; ovf = 1'b0;
      tick();
      drive_idle();
      repeat (9) tick();
      valid = 1'b1; product = 16'h7001; sign = 1'b1;
      tick();
      drive_idle();
      n_vec++; if (led_a !== 17'h17001) begin n_err++; $display("FAIL timeout_recapture_led_a: got %h want %h", led_a, 17'h17001); end
      n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL timeout_recapture_ready_a: got %b want 1", ready_a); end
   endtask

   task automatic test_alarm_blink();
      logic [16:0] pat;
      valid = 1'b1; product = 16'hFFFF; sign = 1'b0; ovf = 1'b1;
      tick();
      drive_idle();
      for (int i = 0; i < 16; i++) begin
         pat = (((i / 4) % 2) == 0) ? 17'h0FFFF : 17'h00000;
         if (i < 10) begin
            n_vec++; if (led_a !== pat) begin n_err++; $display("FAIL blink_led_a[%0d]: got %h want %h", i, led_a, pat); end
            n_vec++; if (alarm_a !== 1'b1 || ready_a !== 1'b1) begin n_err++; $display("FAIL blink_flags_a[%0d]: got %b%b want 11", i, alarm_a, ready_a); end
         end else begin
            n_vec++; if (led_a !== 17'h00000 || ready_a !== 1'b0) begin n_err++; $display("FAIL blink_expired_a[%0d]: got %h/%b want 00000/0", i, led_a, ready_a); end
         end
         n_vec++; if (led_b !== ~pat) begin n_err++; $display("FAIL blink_led_b[%0d]: got %h want %h", i, led_b, ~pat); end
         n_vec++; if (alarm_b !== 1'b1 || ready_b !== 1'b1) begin n_err++; $display("FAIL blink_flags_b[%0d]: got %b%b want 11", i, alarm_b, ready_b); end
         tick();
      end
   endtask

   task automatic test_clear_with_valid();
      valid = 1'b1; product = 16'h0055; sign = 1'b0; ovf = 1'b0;
      tick();
      clear = 1'b1; valid = 1'b1; product = 16'h0001;
      tick();
      drive_idle();
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (led_a !== 17'h00000 || ready_a !== 1'b0) begin n_err++; $display("FAIL clear_a[%0d]: got %h/%b want 00000/0", i, led_a, ready_a); end
         n_vec++; if (led_b !== 17'h1FFFF || ready_b !== 1'b0) begin n_err++; $display("FAIL clear_b[%0d]: got %h/%b want 1ffff/0", i, led_b, ready_b); end
         tick();
      end
   endtask

   task automatic test_act_lo();
      rst_n = 1'b0;
      m_active = 1'b0;
      #1;
      n_vec++; if (led_b !== 17'h1FFFF) begin n_err++; $display("FAIL actlo_reset_led_b: got %h want %h", led_b, 17'h1FFFF); end
      tick();
      rst_n = 1'b1;
      valid = 1'b1; product = 16'h0003; sign = 1'b0; ovf = 1'b0;
      tick();
      drive_idle();
      n_vec++; if (led_b !== 17'h1FFFC) begin n_err++; $display("FAIL actlo_capture_led_b: got %h want %h", led_b, 17'h1FFFC); end
      n_vec++; if (led_a !== 17'h00003) begin n_err++; $display("FAIL actlo_capture_led_a: got %h want %h", led_a, 17'h00003); end
   endtask

   task automatic test_async_reset();
      valid = 1'b1; product = 16'hBEEF; sign = 1'b1; ovf = 1'b1;
      tick();
      drive_idle();
      repeat ($urandom_range(1, 7)) tick();
      #2;
      rst_n = 1'b0;
      m_active = 1'b0;
      #1;
      n_vec++; if (led_a !== 17'h00000 || alarm_a !== 1'b0 || ready_a !== 1'b0) begin n_err++; $display("FAIL async_reset_a: got %h/%b/%b want 00000/0/0", led_a, alarm_a, ready_a); end
      n_vec++; if (led_b !== 17'h1FFFF || alarm_b !== 1'b0) begin n_err++; $display("FAIL async_reset_b: got %h/%b want 1ffff/0", led_b, alarm_b); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++; if (led_b !== 17'h1FFFF || alarm_b !== 1'b0 || ready_b !== 1'b0) begin n_err++; $display("FAIL post_reset_b[%0d]: got %h/%b/%b want 1ffff/0/0", i, led_b, alarm_b, ready_b); end
         n_vec++; if (led_a !== 17'h00000 || alarm_a !== 1'b0) begin n_err++; $display("FAIL post_reset_a[%0d]: got %h/%b want 00000/0", i, led_a, alarm_a); end
      end
   endtask

   task automatic test_random();
      logic [16:0] wa, wb;
      for (int i = 0; i < 400; i++) begin
         valid   = ($urandom_range(0, 99) < 25);
         clear   = ($urandom_range(0, 99) < 4);
         ovf     = ($urandom_range(0, 99) < 40);
         sign    = $urandom_range(0, 1);
         product = 16'($urandom);
         tick();
         wa = exp_led(10, 1'b0);
         wb = exp_led(0, 1'b1);
         n_vec++; if (led_a !== wa) begin n_err++; $display("FAIL rand_led_a[%0d]: got %h want %h", i, led_a, wa); end
         n_vec++; if (ready_a !== m_lit(10)) begin n_err++; $display("FAIL rand_ready_a[%0d]: got %b want %b", i, ready_a, m_lit(10)); end
         n_vec++; if (alarm_a !== (m_lit(10) && m_ovf)) begin n_err++; $display("FAIL rand_alarm_a[%0d]: got %b want %b", i, alarm_a, m_lit(10) && m_ovf); end
         n_vec++; if (led_b !== wb) begin n_err++; $display("FAIL rand_led_b[%0d]: got %h want %h", i, led_b, wb); end
         n_vec++; if (ready_b !== m_lit(0)) begin n_err++; $display("FAIL rand_ready_b[%0d]: got %b want %b", i, ready_b, m_lit(0)); end
         n_vec++; if (alarm_b !== (m_lit(0) && m_ovf)) begin n_err++; $display("FAIL rand_alarm_b[%0d]: got %b want %b", i, alarm_b, m_lit(0) && m_ovf); end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_capture();
      test_hold_timeout();
      test_valid_at_timeout();
      test_alarm_blink();
      test_clear_with_valid();
      test_act_lo();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
